// File: rtl/gf_pkg.sv
// Shared constants, op encodings, FSM states and the xtime helper for the GF(2^4) datapath.
package gf_pkg;

    localparam int              GF_M     = 4;
    localparam logic [GF_M-1:0] GF_POLY  = 4'b0011;
    localparam int              GF_CNT_W = $clog2(GF_M);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Multiply by x, folding the overflow bit back in through the field polynomial.
    function automatic logic [GF_M-1:0] xtime(input logic [GF_M-1:0] x);
        return {x[GF_M-2:0], 1'b0} ^ (x[GF_M-1] ? GF_POLY : '0);
    endfunction

endpackage

// File: rtl/gf_mul_ctrl_if.sv
// Start/result handshake between the point sequencers and gf_mul_ctrl.
// err exists only when GF_START_ERR_EN is defined.
interface gf_mul_ctrl_if;
    import gf_pkg::*;

    logic            start;
    logic            op;
    logic [GF_M-1:0] a;
    logic [GF_M-1:0] b;
    logic            busy;
    logic            done;
    logic [GF_M-1:0] result;

`ifdef GF_START_ERR_EN
    logic            err;

    modport master (output start, op, a, b, input busy, done, result, err);
    modport slave  (input start, op, a, b, output busy, done, result, err);
`else
    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
`endif

endinterface

// File: rtl/gf_step.sv
// One combinational datapath step: a plain field add, or one MSB-first
// shift-and-add multiply iteration (xtime of the accumulator plus a gated A).
module gf_step
    import gf_pkg::*;
(
    input  logic            i_mul,
    input  logic [GF_M-1:0] i_acc,
    input  logic [GF_M-1:0] i_a,
    input  logic [GF_M-1:0] i_b,
    input  logic            i_bit,
    output logic [GF_M-1:0] o_nxt
);

    logic [GF_M-1:0] w_x;
    logic [GF_M-1:0] w_y;

    // NOTE: every output gets a default first so always_comb never infers a latch.
    always_comb begin
        w_x = i_a;
        w_y = i_b;
        if (i_mul) begin
            w_x = xtime(i_acc);
            w_y = i_bit ? i_a : '0;
        end
    end

    xor_add #(.W(GF_M)) u_add (
        .i_x   (w_x),
        .i_y   (w_y),
        .o_sum (o_nxt)
    );

endmodule

// File: rtl/xor_add.sv
// Carry-free GF(2^m) adder: plain bit-wise XOR.
module xor_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_x ^ i_y;

endmodule

// File: rtl/gf_mul_ctrl.sv
// GF(2^4) add/multiply sequencer: FSM, step counter and registers around gf_step.
// Optional sticky start-while-busy flag: define GF_START_ERR_EN.
module gf_mul_ctrl
    import gf_pkg::*;
(
    input logic          clk,
    input logic          rst,
    gf_mul_ctrl_if.slave bus
);

    state_t              r_state;
    logic                r_op;
    logic [GF_M-1:0]     r_a;
    logic [GF_M-1:0]     r_b;
    logic [GF_M-1:0]     r_acc;
    logic [GF_CNT_W-1:0] r_cnt;
    logic [GF_M-1:0]     r_result;
    logic                r_busy;
    logic                r_done;
    logic [GF_M-1:0]     w_acc_next;

    gf_step u_step (
        .i_mul (r_op == OP_MUL),
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_bit (r_b[r_cnt]),
        .o_nxt (w_acc_next)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_acc   <= '0;
                        r_cnt   <= (bus.op == OP_MUL) ? GF_CNT_W'(GF_M - 1) : '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

`ifdef GF_START_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == RUN && bus.start) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif

endmodule

// File: tb/tb_gf_mul_ctrl.sv
// Directed bench for gf_mul_ctrl: expected results queued at start, popped at done.
module tb_gf_mul_ctrl;
    import gf_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gf_mul_ctrl_if bus ();

    gf_mul_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [GF_M-1:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Schoolbook carry-less product followed by reduction by x^4+x+1.
    function automatic logic [GF_M-1:0] gf_ref(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (y[i]) p = p ^ (8'(x) << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (8'b0001_0011 << (i - 4));
        return p[3:0];
    endfunction

    task automatic start_op(input logic op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(exp);
    endtask

    // Called right after driving start; measures edges from acceptance to done.
    task automatic wait_done(input string tag, input int lat, input bit hold, input bit disturb);
        int              k;
        logic [GF_M-1:0] exp_r;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, "_busy_run"}, 8'(bus.busy), 8'h1);
                check({tag, "_done_low"}, 8'(bus.done), 8'h0);
            end
            if (disturb) begin
                bus.start = (k <= 3) ? k[0] : 1'b0;
                if (k <= 3) begin
                    bus.a  = GF_M'($urandom);
                    bus.b  = GF_M'($urandom);
                    bus.op = ~bus.op;
                end
            end else if (!hold && k == 1) begin
                bus.start = 1'b0;
            end
        end while (bus.done !== 1'b1 && k < 12);
        check({tag, "_latency"}, 8'(k - 1), 8'(lat));
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, 8'(bus.result), 8'(exp_r));
        check({tag, "_busy_done"}, 8'(bus.busy), 8'h0);
    endtask

    task automatic do_op(input string tag, input logic op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp);
        start_op(op, a, b, exp);
        wait_done(tag, (op == OP_MUL) ? GF_M : 1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rop;
        int         seen;

        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 8'(bus.busy), 8'h0);
        check("rst_done", 8'(bus.done), 8'h0);
        check("rst_result", 8'(bus.result), 8'h0);
`ifdef GF_START_ERR_EN
        check("rst_err", 8'(bus.err), 8'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_op("add_9_5", OP_ADD, 4'h9, 4'h5, 4'hC);
        do_op("mul_9_5", OP_MUL, 4'h9, 4'h5, 4'hB);
        do_op("mul_2_8", OP_MUL, 4'h2, 4'h8, 4'h3);
        do_op("mul_f_f", OP_MUL, 4'hF, 4'hF, 4'hA);
        do_op("mul_7_1", OP_MUL, 4'h7, 4'h1, 4'h7);
        do_op("mul_7_0", OP_MUL, 4'h7, 4'h0, 4'h0);
        do_op("mul_0_b", OP_MUL, 4'h0, 4'hB, 4'h0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rop = 1'($urandom);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, (rop == OP_MUL) ? gf_ref(ra, rb) : (ra ^ rb));
        end

        // Start and operands wiggle throughout RUN; the in-flight multiply must not notice.
        start_op(OP_MUL, 4'h9, 4'h5, 4'hB);
        wait_done("busy_toggle", GF_M, 1'b0, 1'b1);
`ifdef GF_START_ERR_EN
        check("err_set", 8'(bus.err), 8'h1);
`endif
        @(negedge clk);

        // Start held through DONE: second multiply accepted on the DONE edge.
        start_op(OP_MUL, 4'h2, 4'h8, 4'h3);
        wait_done("b2b_first", GF_M, 1'b1, 1'b0);
        exp_q.push_back(4'h3);
        wait_done("b2b_second", GF_M, 1'b0, 1'b0);
`ifdef GF_START_ERR_EN
        check("err_sticky", 8'(bus.err), 8'h1);
`endif
        @(negedge clk);

        // Reset two cycles into a multiply abandons it with no done pulse.
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 4'h7;
        bus.b     = 4'h3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_busy_before_rst", 8'(bus.busy), 8'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 8'(bus.busy), 8'h0);
        check("mid_rst_done", 8'(bus.done), 8'h0);
        check("mid_rst_result", 8'(bus.result), 8'h0);
`ifdef GF_START_ERR_EN
        check("mid_rst_err", 8'(bus.err), 8'h0);
`endif
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("mid_rst_no_done", 8'(seen), 8'h0);
        check("scoreboard_empty", 8'(exp_q.size()), 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gf_mul_ctrl.md
Name: gf_mul_ctrl

Overview:
- Sequencing controller for the GF(2^4) field datapath in the ECC core.
- Accepts one operation per start handshake: field add (1 step) or field multiply (MSB-first shift-and-add, M steps).
- Each step uses the bit-wise XOR adder, followed by reduction modulo the field polynomial.
- Feeds point add/double sequencers above it.

Parameters:
- M, 4, field degree and operand width; fixed at 4 to match the existing xor_add width.
- POLY, 4'b0011, low M bits of the reduction polynomial (x^4+x+1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  1  0 = add (a^b), 1 = multiply (a*b mod POLY)
- a  input  M  operand A; captured when start is accepted
- b  input  M  operand B; captured when start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result is valid
- result  output  M  last completed result; held until the next completion

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal acc, cnt and operand registers cleared.
  - Applies mid-operation: the operation is abandoned and no done is produced.
- States and transitions:
  - IDLE --start--> RUN.
  - RUN --last step--> DONE.
  - DONE --start--> RUN; DONE --!start--> IDLE.
- Accept (edge E0, state IDLE or DONE, start=1):
  - Latch a, b and op.
  - acc=0.
  - cnt=M-1 for multiply, cnt=0 for add.
  - busy=1 from E0.
- RUN step, one per edge:
  - Add: acc_next = a ^ b.
  - Multiply: acc_next = xtime(acc) ^ (b[cnt] ? a : 0).
  - xtime(x) = {x[M-2:0],1'b0} ^ (x[M-1] ? POLY : 0).
  - When cnt==0: result<=acc_next, state=DONE. Otherwise cnt decrements.
- Latency from the accepting edge E0 to done high:
  - Add: 1 cycle (done high after edge E0+1).
  - Multiply: M cycles (done high after edge E0+M).
- done:
  - High exactly one cycle, in DONE; busy=0 in DONE.
  - Back-to-back: start=1 during DONE is accepted at that edge (no bubble), and done still falls.
- start while busy (RUN): ignored; the operation in flight is unaffected.
- Operand changes on a/b/op after acceptance: no effect.
- Boundary cases:
  - a=0 or b=0 -> result 0.
  - b=1 -> result=a.
  - All arithmetic is carry-free (XOR); no overflow exists.

Optional Feature:
- Macro: GF_START_ERR_EN.
- Defined:
  - Extra output err (1 bit, reset 0).
  - err is sticky: it sets at any edge where start=1 while state=RUN.
  - Only rst clears err.
- Undefined:
  - No err port.
  - start during RUN is silently ignored.

Decomposition:
- Package gf_pkg:
  - GF_M=4 and GF_POLY=4'b0011.
  - op encodings OP_ADD=0, OP_MUL=1.
  - State enum {IDLE, RUN, DONE}.
- Sub-module gf_step (combinational):
  - Computes one xtime plus the conditional add.
  - Instantiates xor_add for the addition.
  - gf_mul_ctrl holds only the FSM, counter and registers.

Test Plan:
- Reset: assert rst during a multiply at cycle 2 -> busy=0, done=0, result=0 next cycle; no done pulse follows.
- Add: op=0, a=0x9, b=0x5 -> done after 1 cycle, result=0xC.
- Multiply: op=1, a=0x9, b=0x5 -> done exactly 4 cycles after acceptance, result=0xB.
  - Also a=0x2, b=0x8 -> 0x3.
  - Also a=0xF, b=0xF -> 0xA.
- Identity/zero: a=0x7, b=0x1 -> 0x7; a=0x7, b=0x0 -> 0x0.
- Back-to-back:
  - start held through DONE with a=0x2, b=0x8 -> second operation accepted at the DONE edge, done pulses 4 cycles apart.
  - Toggling start during RUN does not alter the in-flight result; with GF_START_ERR_EN, err=1 and stays 1 until rst.
